// File: rtl/pdp8_operate_sequencer.sv
// pdp8_operate_sequencer: multi-cycle PDP-8 operate microinstruction executor with start/ready/done handshake
module pdp8_operate_sequencer #(
  parameter int WORD_WIDTH = 12,
  parameter bit MODEL_8E   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  ready,
  input  logic [11:0]           i_reg,
  input  logic [WORD_WIDTH-1:0] ac_in,
  input  logic                  l_in,
  input  logic [WORD_WIDTH-1:0] sr_in,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] ac_out,
  output logic                  l_out,
  output logic                  skip,
  output logic                  halt,
  output logic                  illegal
);
  localparam int W = WORD_WIDTH;
  localparam int H = WORD_WIDTH / 2;
  typedef enum logic [3:0] {
    IDLE, G1_CLR, G1_CMP, G1_INC, G1_ROT1, G1_ROT2, G2_SKP, G2_CLR, G2_OSR, FIN
  } state_t;
  state_t state, state_nx;
  logic [W-1:0] ac, ac_nx;
  logic l, l_nx, skp, skp_nx;
  logic [8:0] ir, op;
  logic g2, g3, ral, rar, bsw, cond, unused_opcode;
  logic [W:0] lac, rot;
  assign unused_opcode = ^i_reg[11:9];
  assign op   = (state == IDLE) ? i_reg[8:0] : ir;
  assign g2   = op[8] & ~op[0];
  assign g3   = op[8] & op[0];
  assign ral  = op[2];
  assign rar  = op[3];
  assign bsw  = MODEL_8E & op[1];
  assign lac  = {l, ac};
  assign rot  = (ral & ~rar) ? {ac, l} :
                (rar & ~ral) ? {ac[0], l, ac[W-1:1]} :
                (bsw & ~ral & ~rar) ? {l, ac[H-1:0], ac[W-1:H]} : lac;
  assign cond = (op[6] & ac[W-1]) | (op[5] & ~|ac) | (op[4] & l);
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // event-order sequencing: every step of a group is always traversed
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !start ? IDLE : g3 ? FIN : g2 ? G2_SKP : G1_CLR;
      G1_CLR:  state_nx = G1_CMP;
      G1_CMP:  state_nx = G1_INC;
      G1_INC:  state_nx = G1_ROT1;
      G1_ROT1: state_nx = G1_ROT2;
      G1_ROT2: state_nx = FIN;
      G2_SKP:  state_nx = G2_CLR;
      G2_CLR:  state_nx = G2_OSR;
      G2_OSR:  state_nx = FIN;
      default: state_nx = IDLE;
    endcase
  end
  // handshake outputs decoded from state
  always_comb begin
    ready = (state == IDLE);
    done  = (state == FIN);
  end
  // per-step datapath update of the working link/accumulator
  always_comb begin
    ac_nx  = ac;
    l_nx   = l;
    skp_nx = skp;
    case (state)
      IDLE: begin
        ac_nx  = start ? ac_in : ac;
        l_nx   = start ? l_in : l;
        skp_nx = start ? 1'b0 : skp;
      end
      G1_CLR: begin
        ac_nx = op[7] ? '0 : ac;
        l_nx  = op[6] ? 1'b0 : l;
      end
      G1_CMP: begin
        ac_nx = op[5] ? ~ac : ac;
        l_nx  = op[4] ? ~l : l;
      end
      G1_INC:  {l_nx, ac_nx} = op[0] ? lac + (W+1)'(1) : lac;
      G1_ROT1: {l_nx, ac_nx} = rot;
      G1_ROT2: {l_nx, ac_nx} = (bsw & (ral ^ rar)) ? rot : lac;
      G2_SKP:  skp_nx = op[3] ? ~cond : cond;
      G2_CLR:  ac_nx = op[7] ? '0 : ac;
      G2_OSR:  ac_nx = op[2] ? ac | sr_in : ac;
      default: ac_nx = ac;
    endcase
  end
  // working registers, instruction captured on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac  <= '0;
      l   <= 1'b0;
      skp <= 1'b0;
      ir  <= '0;
    end else begin
      ac  <= ac_nx;
      l   <= l_nx;
      skp <= skp_nx;
      ir  <= (state == IDLE && start) ? i_reg[8:0] : ir;
    end
  end
  // results published on entry to FIN and held until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_out  <= '0;
      l_out   <= 1'b0;
      skip    <= 1'b0;
      halt    <= 1'b0;
      illegal <= 1'b0;
    end else if (state_nx == FIN) begin
      ac_out  <= ac_nx;
      l_out   <= l_nx;
      skip    <= skp_nx;
      halt    <= g2 & op[1];
      illegal <= g3 | (~op[8] & ral & rar);
    end
  end
endmodule

// File: tb/tb_pdp8_operate_sequencer.sv
// tb_pdp8_operate_sequencer: randomized and directed checks of three configurations against a behavioural model
module tb_pdp8_operate_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, l_in = 1'b0;
  logic [11:0] i_reg = '0;
  logic [15:0] ac_r = '0, sr_r = '0;
  logic rdy [3], dn [3], lo [3], sk [3], hl [3], il [3];
  logic [11:0] ac_o0;
  logic [15:0] ac_o1, ac_o2;
  logic [15:0] g_ac [3];
  assign g_ac[0] = {4'h0, ac_o0};
  assign g_ac[1] = ac_o1;
  assign g_ac[2] = ac_o2;
  always #5 clk = ~clk;

  pdp8_operate_sequencer #(.WORD_WIDTH(12), .MODEL_8E(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(rdy[0]), .i_reg(i_reg),
    .ac_in(ac_r[11:0]), .l_in(l_in), .sr_in(sr_r[11:0]), .done(dn[0]), .ac_out(ac_o0),
    .l_out(lo[0]), .skip(sk[0]), .halt(hl[0]), .illegal(il[0]));
  pdp8_operate_sequencer #(.WORD_WIDTH(16), .MODEL_8E(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(rdy[1]), .i_reg(i_reg),
    .ac_in(ac_r), .l_in(l_in), .sr_in(sr_r), .done(dn[1]), .ac_out(ac_o1),
    .l_out(lo[1]), .skip(sk[1]), .halt(hl[1]), .illegal(il[1]));
  pdp8_operate_sequencer #(.WORD_WIDTH(16), .MODEL_8E(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(rdy[2]), .i_reg(i_reg),
    .ac_in(ac_r), .l_in(l_in), .sr_in(sr_r), .done(dn[2]), .ac_out(ac_o2),
    .l_out(lo[2]), .skip(sk[2]), .halt(hl[2]), .illegal(il[2]));

  typedef struct packed {logic [15:0] ac; logic l, skip, halt, ill;} res_t;
  typedef struct packed {
    logic [11:0] op; logic [15:0] ac; logic l; logic [15:0] sr;
    logic [15:0] eac; logic el, esk, eh, ei; logic [3:0] lat;
  } dir_t;

  int  wd [3] = '{12, 16, 16};
  bit  m8 [3] = '{1'b1, 1'b1, 1'b0};
  res_t e [3];
  bit  e_ready = 1'b1, e_done = 1'b0, cmp_en = 1'b0;
  int  phase = 0, cnt = 0, checks = 0, errors = 0;
  logic [11:0] m_op;
  logic [15:0] m_ac;
  logic m_l;

  // result of a whole operate instruction, computed directly from the instruction semantics
  function automatic res_t exec(input int w, input bit m, input logic [11:0] op,
                                input int ac, input bit l, input int sr);
    res_t r;
    int mask, full, a, k, v;
    bit any;
    mask = (1 << w) - 1;
    full = (1 << (w + 1)) - 1;
    a = ac & mask;
    k = int'(l);
    r = '0;
    if (op[8] && op[0]) r.ill = 1'b1;
    else if (op[8]) begin
      any = (op[6] && a >= (1 << (w - 1))) || (op[5] && a == 0) || (op[4] && k == 1);
      r.skip = op[3] ? !any : any;
      if (op[7]) a = 0;
      if (op[2]) a = a | (sr & mask);
      r.halt = op[1];
    end else begin
      if (op[7]) a = 0;
      if (op[6]) k = 0;
      if (op[5]) a = ~a & mask;
      if (op[4]) k = 1 - k;
      v = (k << w) + a;
      if (op[0]) v = (v + 1) & full;
      if (op[2] && op[3]) r.ill = 1'b1;
      else if (op[2] || op[3]) begin
        repeat ((m && op[1]) ? 2 : 1)
          v = op[2] ? (((v << 1) | (v >> w)) & full) : ((v >> 1) | ((v & 1) << w));
      end else if (m && op[1])
        v = (v & ~mask) | ((v & ((1 << (w / 2)) - 1)) << (w / 2)) | ((v & mask) >> (w / 2));
      k = (v >> w) & 1;
      a = v & mask;
    end
    r.ac = 16'(a);
    r.l  = (k == 1);
    return r;
  endfunction

  // transaction-level model: idle / busy with remaining latency / done
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0;
      for (int c = 0; c < 3; c++) e[c] = '0;
    end else begin
      if (phase == 2) phase = 0;
      else if (phase == 1) cnt = cnt - 1;
      else if (start) begin
        m_op = i_reg; m_ac = ac_r; m_l = l_in;
        cnt = (i_reg[8] && i_reg[0]) ? 0 : i_reg[8] ? 3 : 5;
        phase = 1;
      end
      if (phase == 1 && cnt == 0) begin
        for (int c = 0; c < 3; c++) e[c] = exec(wd[c], m8[c], m_op, int'(m_ac), m_l, int'(sr_r));
        phase = 2;
      end
    end
    e_ready = (phase == 0);
    e_done  = (phase == 2);
  end

  // every-cycle comparison of all three DUTs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({rdy[c], dn[c], lo[c], sk[c], hl[c], il[c], g_ac[c]} !==
            {e_ready, e_done, e[c].l, e[c].skip, e[c].halt, e[c].ill, e[c].ac}) begin
          errors++;
          $display("FAIL cycle cfg%0d t=%0t got rdy=%b done=%b l=%b skip=%b halt=%b ill=%b ac=%h required rdy=%b done=%b l=%b skip=%b halt=%b ill=%b ac=%h",
                   c, $time, rdy[c], dn[c], lo[c], sk[c], hl[c], il[c], g_ac[c],
                   e_ready, e_done, e[c].l, e[c].skip, e[c].halt, e[c].ill, e[c].ac);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic run(input logic [11:0] op, input logic [15:0] ac, input bit l,
                     input logic [15:0] sr, output int lat);
    int n = 0;
    while (!rdy[0] && n < 20) begin @(negedge clk); n++; end
    if (!rdy[0]) chk("ready_wait", 0, 1);
    i_reg = op; ac_r = ac; l_in = l; sr_r = sr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!dn[0] && lat < 10) begin @(negedge clk); lat++; end
  endtask

  dir_t tbl [13] = '{
    '{12'o7240, 16'o1234, 1'b1, 16'o0,    16'o7777, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5},
    '{12'o7001, 16'o7777, 1'b0, 16'o0,    16'o0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5},
    '{12'o7001, 16'o7777, 1'b1, 16'o0,    16'o0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5},
    '{12'o7006, 16'o4001, 1'b1, 16'o0,    16'o0007, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5},
    '{12'o7012, 16'o0003, 1'b0, 16'o0,    16'o4000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5},
    '{12'o7002, 16'h1234, 1'b0, 16'o0,    16'o6410, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5},
    '{12'o7540, 16'o4000, 1'b0, 16'o0,    16'o4000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3},
    '{12'o7510, 16'o4000, 1'b0, 16'o0,    16'o4000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3},
    '{12'o7410, 16'o0000, 1'b1, 16'o0,    16'o0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3},
    '{12'o7604, 16'o1111, 1'b0, 16'o5252, 16'o5252, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3},
    '{12'o7402, 16'o0123, 1'b1, 16'o0,    16'o0123, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3},
    '{12'o7401, 16'o2345, 1'b1, 16'o0,    16'o2345, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0},
    '{12'o7014, 16'o1234, 1'b0, 16'o0,    16'o1234, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5}
  };

  initial begin
    int lat, n;
    res_t r;
    r = exec(12, 1'b1, 12'o7006, 'o4001, 1'b1, 0);
    chk("model_rtl_ac", int'(r.ac), 'o0007);
    chk("model_rtl_l", int'(r.l), 0);
    r = exec(16, 1'b1, 12'o7002, 'h1234, 1'b0, 0);
    chk("model_bsw16", int'(r.ac), 'h3412);
    r = exec(16, 1'b0, 12'o7002, 'h1234, 1'b0, 0);
    chk("model_bsw16_no8e", int'(r.ac), 'h1234);
    r = exec(12, 1'b1, 12'o7540, 'o4000, 1'b0, 0);
    chk("model_sma_sza", int'(r.skip), 1);
    r = exec(12, 1'b1, 12'o7604, 'o1111, 1'b0, 'o5252);
    chk("model_cla_osr", int'(r.ac), 'o5252);
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_ready", int'(rdy[0]), 1);
    chk("reset_outs", int'({dn[0], lo[0], sk[0], hl[0], il[0], ac_o0}), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      run(tbl[i].op, tbl[i].ac, tbl[i].l, tbl[i].sr, lat);
      chk($sformatf("lat_%0o", tbl[i].op), lat, int'(tbl[i].lat));
      chk($sformatf("ac_%0o", tbl[i].op), int'(ac_o0), int'(tbl[i].eac));
      chk($sformatf("l_%0o", tbl[i].op), int'(lo[0]), int'(tbl[i].el));
      chk($sformatf("skip_%0o", tbl[i].op), int'(sk[0]), int'(tbl[i].esk));
      chk($sformatf("halt_%0o", tbl[i].op), int'(hl[0]), int'(tbl[i].eh));
      chk($sformatf("illegal_%0o", tbl[i].op), int'(il[0]), int'(tbl[i].ei));
      if (tbl[i].op == 12'o7002) begin
        chk("bsw16_8e", int'(ac_o1), 'h3412);
        chk("bsw16_no8e", int'(ac_o2), 'h1234);
      end
    end
    @(negedge clk);
    i_reg = 12'o7001; ac_r = 16'h0; l_in = 1'b0; start = 1'b1;
    @(negedge clk);
    i_reg = 12'o7200; ac_r = 16'o777;
    repeat (2) @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!dn[0] && n < 10) begin @(negedge clk); n++; end
    chk("busy_ignored_ac", int'(ac_o0), 1);
    n = 0;
    repeat (8) begin @(negedge clk); if (dn[0]) n++; end
    chk("busy_not_queued", n, 0);
    i_reg = 12'o7240; ac_r = 16'o1234; l_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ready", int'(rdy[0]), 1);
    chk("abort_outs", int'({dn[0], lo[0], sk[0], hl[0], il[0], ac_o0}), 0);
    #2 rst_n = 1'b1;
    n = 0;
    repeat (8) begin @(negedge clk); if (dn[0]) n++; end
    chk("abort_no_done", n, 0);
    chk("abort_ready_after", int'(rdy[0]), 1);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      i_reg = 12'o7000 | 12'($urandom_range(0, 511));
      ac_r = 16'($urandom);
      l_in = 1'($urandom);
      sr_r = 16'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
